// File: rtl/ch0re_ifetch.sv
// ch0re_ifetch -- instruction fetch unit for the Ch0re RV64I pipeline.
//
// Keeps the fetch PC, issues in-order imem requests under a credit limit,
// buffers returned words with their PCs in a small prefetch FIFO and feeds
// the decode stage one {pc, instr} entry per cycle through an output
// register. A redirect (taken branch/jump) empties the FIFO and discards
// every response still in flight.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_stall             decode stall; holds the output register
//   i_redirect          redirect fetch to i_redirect_pc this cycle
//   i_redirect_pc       new fetch target (bits [1:0] ignored)
//   o_imem_req/addr     request and its address (the fetch PC)
//   i_imem_gnt          request accepted
//   i_imem_rvalid/rdata in-order response
//   o_instr/o_pc        instruction and PC to decode (NOP when invalid)
//   o_valid             o_instr is a real fetched instruction
module ch0re_ifetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [63:0] o_pc,
  output logic        o_valid
);

  localparam int unsigned AW  = $clog2(BUF_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW-1:0]   DEPTH_C = CW'(BUF_DEPTH);
  // credit sum of three counters needs two extra bits before the compare
  localparam logic [CW+1:0]   DEPTH_W = (CW+2)'(BUF_DEPTH);

  // ---------------------------------------------------------------- state
  logic [63:0]   fpc_q, fpc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;
  logic [AW-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic [AW-1:0] pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;

  logic [63:0] buf_pc_q    [BUF_DEPTH];
  logic [63:0] buf_pc_d    [BUF_DEPTH];
  logic [31:0] buf_instr_q [BUF_DEPTH];
  logic [31:0] buf_instr_d [BUF_DEPTH];
  logic [63:0] pcq_q       [BUF_DEPTH];
  logic [63:0] pcq_d       [BUF_DEPTH];

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [63:0] pc_q, pc_d;

  // ------------------------------------------------------- control terms
  logic          pop, req, fire, rsp_drop, rsp_acc, push;
  logic [CW+1:0] credit_used;

  // redirect address bits [1:0] are forced to zero and never read
  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^i_redirect_pc[1:0];

  always_comb begin
    pop = !i_stall && (buf_cnt_q != '0) && !i_redirect;
    // an entry leaving the FIFO this cycle frees its slot for a new request
    credit_used = {2'b00, out_cnt_q} + {2'b00, drop_cnt_q} + {2'b00, buf_cnt_q}
                - (CW+2)'(pop);
    req      = !rst && !i_redirect && (credit_used < DEPTH_W);
    fire     = req && i_imem_gnt;
    rsp_drop = i_imem_rvalid && (drop_cnt_q != '0);
    rsp_acc  = i_imem_rvalid && (drop_cnt_q == '0);
    push     = rsp_acc && !i_redirect;
  end

  assign o_imem_req  = req;
  assign o_imem_addr = fpc_q;

  // ---------------------------------------------------- fetch/buffer next
  always_comb begin
    fpc_d       = fpc_q;
    out_cnt_d   = out_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    buf_cnt_d   = buf_cnt_q;
    buf_rd_d    = buf_rd_q;
    buf_wr_d    = buf_wr_q;
    pcq_rd_d    = pcq_rd_q;
    pcq_wr_d    = pcq_wr_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    pcq_d       = pcq_q;

    if (i_redirect) begin
      fpc_d      = {i_redirect_pc[63:2], 2'b00};
      // everything outstanding becomes stale; a response landing now is
      // already one of them and is consumed here
      drop_cnt_d = drop_cnt_q + out_cnt_q - CW'(i_imem_rvalid);
      out_cnt_d  = '0;
      buf_cnt_d  = '0;
      buf_rd_d   = '0;
      buf_wr_d   = '0;
      pcq_rd_d   = '0;
      pcq_wr_d   = '0;
    end else begin
      if (fire) begin
        fpc_d           = fpc_q + 64'd4;
        pcq_d[pcq_wr_q] = fpc_q;
        pcq_wr_d        = pcq_wr_q + AW'(1);
      end
      out_cnt_d = out_cnt_q + CW'(fire) - CW'(rsp_acc);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
      if (push) begin
        buf_pc_d[buf_wr_q]    = pcq_q[pcq_rd_q];
        buf_instr_d[buf_wr_q] = i_imem_rdata;
        buf_wr_d              = buf_wr_q + AW'(1);
        pcq_rd_d              = pcq_rd_q + AW'(1);
      end
      if (pop) buf_rd_d = buf_rd_q + AW'(1);
      buf_cnt_d = buf_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // ------------------------------------------------------- output stage
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (i_redirect) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (!i_stall) begin
      if (buf_cnt_q != '0) begin
        valid_d = 1'b1;
        instr_d = buf_instr_q[buf_rd_q];
        pc_d    = buf_pc_q[buf_rd_q];
      end else begin
        valid_d = 1'b0;
        instr_d = NOP;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_instr = instr_q;
  assign o_pc    = pc_q;

  // ------------------------------------------------------------- flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q      <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      buf_cnt_q  <= '0;
      buf_rd_q   <= '0;
      buf_wr_q   <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
      valid_q    <= 1'b0;
      instr_q    <= NOP;
      pc_q       <= '0;
    end else begin
      fpc_q      <= fpc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      buf_rd_q   <= buf_rd_d;
      buf_wr_q   <= buf_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  // storage arrays carry no reset; occupancy is tracked by the counters
  always_ff @(posedge clk) begin
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
    pcq_q       <= pcq_d;
  end

  // --------------------------------------------------------- assertions
  // credit accounting must keep the FIFO from overflowing
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (buf_cnt_q == DEPTH_C) && !pop));

  // a response must always match an outstanding or stale request
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(i_imem_rvalid && (drop_cnt_q == '0) && (out_cnt_q == '0)));

endmodule

// File: tb/tb_ch0re_ifetch.sv
module tb_ch0re_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [63:0] i_redirect_pc = 64'h0;
  logic        i_imem_gnt = 1'b0;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  logic        o_valid;

  always #5 clk = ~clk;

  ch0re_ifetch #(.RESET_PC(64'h0), .BUF_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_stall(i_stall), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  // in-order memory model: rdata = request address, fixed latency per grant
  typedef struct { logic [31:0] data; int due; } rsp_t;
  rsp_t mq[$];
  int   cyc_n;
  int   lat;
  int   n_chk;
  int   n_fail;
  int   found;
  logic        last_req;
  logic [63:0] last_addr;

  typedef struct {
    logic        stall;
    logic        gnt;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [63:0] exp_pc;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // one clock cycle: entered and left at the falling edge, inputs already set
  task automatic cyc();
    #1;
    last_req  = o_imem_req;
    last_addr = o_imem_addr;
    if (mq.size() > 0 && mq[0].due <= cyc_n) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mq[0].data;
      void'(mq.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
    end
    if (o_imem_req && i_imem_gnt) mq.push_back('{o_imem_addr[31:0], cyc_n + lat});
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic run_row(input vec_t v, input string tag);
    i_stall    = v.stall;
    i_imem_gnt = v.gnt;
    cyc();
    chk({tag, "_req"},   64'(last_req), 64'(v.exp_req));
    chk({tag, "_addr"},  last_addr, v.exp_addr);
    chk({tag, "_valid"}, 64'(o_valid), 64'(v.exp_valid));
    chk({tag, "_pc"},    o_pc, v.exp_pc);
    chk({tag, "_instr"}, 64'(o_instr), 64'(v.exp_valid ? v.exp_pc[31:0] : NOP));
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc_n = 0; lat = 1;
    //           stall gnt req addr     valid pc
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 64'd0,  1'b0, 64'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 64'd4,  1'b0, 64'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 64'd8,  1'b1, 64'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 64'd12, 1'b1, 64'd4};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 64'd16, 1'b1, 64'd8};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 64'd20, 1'b1, 64'd8};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 64'd24, 1'b1, 64'd8};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 64'd28, 1'b1, 64'd8};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 64'd28, 1'b1, 64'd12};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 64'd32, 1'b1, 64'd16};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 64'd36, 1'b1, 64'd20};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 64'd36, 1'b1, 64'd24};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 64'd36, 1'b1, 64'd28};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 64'd36, 1'b1, 64'd32};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 64'd36, 1'b0, 64'd32};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_instr", 64'(o_instr), 64'(NOP));
    chk("rst_pc",    o_pc, 64'd0);
    chk("rst_req",   64'(o_imem_req), 64'd0);
    rst = 1'b0;

    // streaming, 3-cycle stall, then grant withheld until the FIFO drains
    for (int i = 0; i < 15; i++) run_row(vecs[i], $sformatf("row%0d", i));

    // redirect to 0x100 with two requests outstanding at 3-cycle latency
    lat = 3; i_imem_gnt = 1'b1;
    cyc(); chk("rd_pre0_addr", last_addr, 64'd36);
    cyc(); chk("rd_pre1_addr", last_addr, 64'd40);
    i_redirect = 1'b1; i_redirect_pc = 64'h100;
    cyc();
    chk("rd_cyc_req",   64'(last_req), 64'd0);
    chk("rd_valid",     64'(o_valid), 64'd0);
    chk("rd_instr",     64'(o_instr), 64'(NOP));
    i_redirect = 1'b0;
    cyc();
    chk("rd_next_req",  64'(last_req), 64'd1);
    chk("rd_next_addr", last_addr, 64'h100);
    found = 0;
    for (int k = 0; k < 20 && found < 2; k++) begin
      cyc();
      if (o_valid) begin
        chk(found == 0 ? "rd_first_pc" : "rd_second_pc", o_pc, found == 0 ? 64'h100 : 64'h104);
        found++;
      end
    end
    chk("rd_found", 64'(found), 64'd2);

    // redirect together with stall: bubble, not hold
    i_stall = 1'b1; i_redirect = 1'b1; i_redirect_pc = 64'h202;
    cyc();
    chk("rs_cyc_req", 64'(last_req), 64'd0);
    chk("rs_valid",   64'(o_valid), 64'd0);
    chk("rs_instr",   64'(o_instr), 64'(NOP));
    chk("rs_pc_hold", o_pc, 64'h104);
    i_stall = 1'b0; i_redirect = 1'b0; lat = 1;
    cyc();
    chk("rs_next_req",  64'(last_req), 64'd1);
    chk("rs_next_addr", last_addr, 64'h200);
    found = 0;
    for (int k = 0; k < 20 && found < 2; k++) begin
      cyc();
      if (o_valid) begin
        chk(found == 0 ? "rs_first_pc" : "rs_second_pc", o_pc, found == 0 ? 64'h200 : 64'h204);
        found++;
      end
    end
    chk("rs_found", 64'(found), 64'd2);

    // reset asserted mid-stream, outputs clear without a clock edge
    rst = 1'b1;
    #1;
    chk("mrst_valid", 64'(o_valid), 64'd0);
    chk("mrst_instr", 64'(o_instr), 64'(NOP));
    chk("mrst_req",   64'(o_imem_req), 64'd0);
    chk("mrst_pc",    o_pc, 64'd0);
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    i_imem_rvalid = 1'b0;
    cyc_n = 0; lat = 1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_row(vecs[i], $sformatf("restart%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard stop if the stimulus ever stalls
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

endmodule
